// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit synchroniser, per-channel debounce FSM, sticky startup-valid flag.
// Optional macro SW_DEBOUNCE_EDGE_EN adds registered sw_rise/sw_fall single-cycle pulses.
module sw_debounce #(
  parameter int N_CH         = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic            clk_pin,
  input  logic            rst_pin,
  input  logic [N_CH-1:0] sw_pin,
  output logic [N_CH-1:0] sw_db,
`ifdef SW_DEBOUNCE_EDGE_EN
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
`endif
  output logic            sw_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(SYNC_STAGES + DEBOUNCE_CYC);

  typedef enum logic {STABLE, CHANGING} state_t;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  s;
  state_t                           state_q [N_CH];
  state_t                           state_d [N_CH];
  logic [CNT_W-1:0]                 cnt_q [N_CH];
  logic [CNT_W-1:0]                 cnt_d [N_CH];
  logic [N_CH-1:0]                  db_d;
  logic [CNT_W-1:0]                 start_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_pin or posedge rst_pin) begin
    if (rst_pin) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_pin};
    end
  end

  always_comb begin
    db_d = sw_db;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          if (s[i] != sw_db[i]) begin
            state_d[i] = CHANGING;
            cnt_d[i]   = '0;
          end
        end
        CHANGING: begin
          if (s[i] == sw_db[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            // Window completed without a reversal: accept the new level.
            db_d[i]    = s[i];
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pin or posedge rst_pin) begin
    if (rst_pin) begin
      sw_db <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sw_db <= db_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Startup counter saturates once the first full sync+debounce window has elapsed.
  always_ff @(posedge clk_pin or posedge rst_pin) begin
    if (rst_pin) begin
      start_q  <= '0;
      sw_valid <= 1'b0;
    end else if (!sw_valid) begin
      if (start_q == START_LAST) begin
        sw_valid <= 1'b1;
      end else begin
        start_q <= start_q + CNT_W'(1);
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Gated by the pre-edge valid so the startup-window update never pulses.
  always_ff @(posedge clk_pin or posedge rst_pin) begin
    if (rst_pin) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= sw_valid ? (db_d & ~sw_db) : '0;
      sw_fall <= sw_valid ? (~db_d & sw_db) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: a cycle model feeds an expected-value queue checked each negedge,
// plus directed checks of the startup, latency, glitch, bounce and async-reset cases.
module tb_sw_debounce;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_pin = '0;
  logic [N-1:0] sw_db;
  logic         sw_valid;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sw_debounce #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .CNT_W(8)
  ) dut (
    .clk_pin (clk),
    .rst_pin (rst),
    .sw_pin  (sw_pin),
    .sw_db   (sw_db),
`ifdef SW_DEBOUNCE_EDGE_EN
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
`endif
    .sw_valid(sw_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] db;
    logic         valid;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a level is accepted after DEB+1 consecutive mismatching edges.
  logic [SYNC-1:0][N-1:0] m_sync;
  logic [N-1:0]           m_db, m_rise, m_fall, m_s, m_nd;
  logic                   m_valid;
  int                     m_run [N];
  int                     m_edges;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sync = '0; m_db = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0; m_edges = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        exp_q.push_back('{db: '0, valid: 1'b0, rise: '0, fall: '0});
      end else begin
        m_s  = m_sync[SYNC-1];
        m_nd = m_db;
        for (int i = 0; i < N; i++) begin
          if (m_s[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              m_nd[i]  = m_s[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_rise  = m_valid ? (m_nd & ~m_db) : '0;
        m_fall  = m_valid ? (~m_nd & m_db) : '0;
        m_db    = m_nd;
        m_sync  = {m_sync[SYNC-2:0], sw_pin};
        m_edges++;
        if (m_edges >= LAT) m_valid = 1'b1;
        exp_q.push_back('{db: m_db, valid: m_valid, rise: m_rise, fall: m_fall});
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q[$];
        exp_q.delete();
        chk("sb_db", sw_db, e.db);
        chk("sb_valid", 8'(sw_valid), 8'(e.valid));
`ifdef SW_DEBOUNCE_EDGE_EN
        chk("sb_rise", sw_rise, e.rise);
        chk("sb_fall", sw_fall, e.fall);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset with sw_pin already applied; sw_db and sw_valid appear together at edge LAT.
  task automatic release_check(input logic [N-1:0] lvl, input string tag);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk({tag, "_db"}, sw_db, (k >= LAT) ? lvl : 8'h00);
      chk({tag, "_valid"}, 8'(sw_valid), (k >= LAT) ? 8'h01 : 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk({tag, "_rise"}, sw_rise, 8'h00);
`endif
    end
  endtask

  initial begin
    // Reset state with all switches low.
    rst = 1'b1; sw_pin = 8'h00;
    repeat (3) tick();
    chk("rst_db", sw_db, 8'h00);
    chk("rst_valid", 8'(sw_valid), 8'h00);
    release_check(8'h00, "start0");
    repeat (3) tick();
    chk("valid_hold", 8'(sw_valid), 8'h01);

    // Switches held high through reset.
    rst = 1'b1; sw_pin = 8'hA5;
    repeat (3) tick();
    release_check(8'hA5, "startA5");
    sw_pin = 8'h00;
    repeat (12) tick();
    chk("fall_settle", sw_db, 8'h00);

    // Single rising channel after valid.
    sw_pin = 8'h01;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk("rise0_db", sw_db, (k >= LAT) ? 8'h01 : 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("rise0_pulse", sw_rise, (k == LAT) ? 8'h01 : 8'h00);
`endif
    end
    sw_pin = 8'h00;
    repeat (12) tick();

    // Three-cycle glitch on channel 3 must be rejected.
    sw_pin = 8'h08;
    repeat (3) tick();
    sw_pin = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_db", sw_db, 8'h00);
    end

    // Bounce on channel 1, then hold high.
    sw_pin = 8'h02; tick();
    sw_pin = 8'h00; tick();
    sw_pin = 8'h02; tick();
    sw_pin = 8'h00; tick();
    sw_pin = 8'h02;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk("bounce_db", sw_db, (k >= LAT) ? 8'h02 : 8'h00);
    end

    // Async reset mid-window on channel 7.
    sw_pin = 8'h82;
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_db", sw_db, 8'h00);
    chk("arst_valid", 8'(sw_valid), 8'h00);
    sw_pin = 8'hA5;
    tick();
    release_check(8'hA5, "rerel");

    // Sparse random toggling exercises glitches of all lengths against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0)
        sw_pin = sw_pin ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      tick();
    end
    repeat (12) tick();
    chk("rand_settle", sw_db, sw_pin);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
